// File: rtl/clk_mon_pkg.sv
// Shared types and default constants for the clock phase monitor.
// The state encoding is visible on o_state, so the values are fixed.
package clk_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_SLIP    = 2'd3
    } mon_state_e;

    localparam int DEF_LOCK_CYCLES   = 16;
    localparam int DEF_UNLOCK_ERRORS = 4;
    localparam int DEF_SYNC_STAGES   = 2;

endpackage

// File: rtl/clk_phase_monitor_sync_bit.sv
// N-flop single-bit synchronizer with synchronous reset to 0.
// Used to bring an asynchronous level into the clk domain.
module sync_bit #(
    parameter int N = clk_mon_pkg::DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic srst,
    input  logic d,
    output logic q
);

    logic [N-1:0] stage_q;
    logic [N-1:0] stage_d;

    always_comb begin
        stage_d = {stage_q[N-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[N-1];

endmodule

// File: rtl/clk_phase_monitor.sv
// Samples a phase-shifted copy of the CPU clock on the CPU clock and tracks
// whether the expected phase relationship holds: acquire, lock, slip, unlock.
module clk_phase_monitor
    import clk_mon_pkg::*;
#(
    parameter logic EXPECT_LEVEL  = 1'b0,
    parameter int   SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int   LOCK_CYCLES   = DEF_LOCK_CYCLES,
    parameter int   UNLOCK_ERRORS = DEF_UNLOCK_ERRORS,
    parameter int   ERR_CNT_W     = 16
) (
    input  logic                 i_cpu_ck,
    input  logic                 i_cpu_reset,
    input  logic                 i_cpu_ck_ps,
    input  logic                 i_enable,
    input  logic                 i_clear_err,
    output logic                 o_locked,
    output logic                 o_lock_lost,
    output logic [1:0]           o_state,
    output logic                 o_sample,
    output logic [ERR_CNT_W-1:0] o_err_count
);

    localparam int GOOD_W = $clog2(LOCK_CYCLES + 1);
    localparam int BAD_W  = $clog2(UNLOCK_ERRORS + 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CYCLES - 1);
    localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(UNLOCK_ERRORS - 1);

    mon_state_e           state_q, state_d;
    logic [GOOD_W-1:0]    good_cnt_q, good_cnt_d;
    logic [BAD_W-1:0]     bad_cnt_q, bad_cnt_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 lock_lost_q, lock_lost_d;
    logic                 err_inc;
    logic                 sample;
    logic                 match;

    sync_bit #(
        .N(SYNC_STAGES)
    ) u_sync (
        .clk (i_cpu_ck),
        .srst(i_cpu_reset),
        .d   (i_cpu_ck_ps),
        .q   (sample)
    );

    assign match = (sample == EXPECT_LEVEL);

    always_comb begin
        state_d     = state_q;
        good_cnt_d  = good_cnt_q;
        bad_cnt_d   = bad_cnt_q;
        err_cnt_d   = err_cnt_q;
        lock_lost_d = 1'b0;
        err_inc     = 1'b0;

        if (!i_enable) begin
            state_d    = ST_IDLE;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d    = ST_ACQUIRE;
                    good_cnt_d = '0;
                end
                ST_ACQUIRE: begin
                    if (match) begin
                        good_cnt_d = good_cnt_q + GOOD_W'(1);
                        if (good_cnt_q == GOOD_LAST) begin
                            state_d   = ST_LOCKED;
                            bad_cnt_d = '0;
                        end
                    end else begin
                        good_cnt_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (!match) begin
                        err_inc   = 1'b1;
                        bad_cnt_d = BAD_W'(1);
                        // A single tolerated error means the first slip is already fatal.
                        if (UNLOCK_ERRORS == 1) begin
                            state_d     = ST_ACQUIRE;
                            good_cnt_d  = '0;
                            lock_lost_d = 1'b1;
                        end else begin
                            state_d = ST_SLIP;
                        end
                    end
                end
                ST_SLIP: begin
                    if (match) begin
                        state_d   = ST_LOCKED;
                        bad_cnt_d = '0;
                    end else begin
                        err_inc   = 1'b1;
                        bad_cnt_d = bad_cnt_q + BAD_W'(1);
                        if (bad_cnt_q == BAD_LAST) begin
                            state_d     = ST_ACQUIRE;
                            good_cnt_d  = '0;
                            lock_lost_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Clear beats a coincident increment; the count sticks at all-ones.
        if (i_clear_err) begin
            err_cnt_d = '0;
        end else if (err_inc && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge i_cpu_ck) begin
        if (i_cpu_reset) begin
            state_q     <= ST_IDLE;
            good_cnt_q  <= '0;
            bad_cnt_q   <= '0;
            err_cnt_q   <= '0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            good_cnt_q  <= good_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            err_cnt_q   <= err_cnt_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign o_locked    = (state_q == ST_LOCKED) || (state_q == ST_SLIP);
    assign o_lock_lost = lock_lost_q;
    assign o_state     = state_q;
    assign o_sample    = sample;
    assign o_err_count = err_cnt_q;

endmodule

// File: tb/tb_clk_phase_monitor.sv
// Bench for clk_phase_monitor: a default instance and a small-counter instance
// share stimulus and are compared every cycle against a behavioural model.
`timescale 1ps/1ps
module tb_clk_phase_monitor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic clr = 1'b0;
    logic force_en = 1'b0;
    logic force_val = 1'b0;
    logic ps_nom = 1'b0;
    logic ps;

    logic       a_locked, a_lost, a_sample;
    logic [1:0] a_state;
    logic [15:0] a_err;
    logic       b_locked, b_lost, b_sample;
    logic [1:0] b_state;
    logic [3:0] b_err;

    int vectors = 0;
    int miscompares = 0;

    // Model state, index 0 = default instance, 1 = ERR_CNT_W=4/UNLOCK_ERRORS=32
    bit m_active[2];
    bit m_locked[2];
    bit m_lost[2];
    int m_run[2];
    int m_miss[2];
    int m_err[2];
    bit m_sync0, m_sync1;

    always #1250 clk = ~clk;
    always @(posedge clk) begin #625; ps_nom = 1'b1; end
    always @(negedge clk) begin #625; ps_nom = 1'b0; end
    assign ps = force_en ? force_val : ps_nom;

    clk_phase_monitor dut_a (
        .i_cpu_ck(clk), .i_cpu_reset(rst), .i_cpu_ck_ps(ps),
        .i_enable(en), .i_clear_err(clr),
        .o_locked(a_locked), .o_lock_lost(a_lost), .o_state(a_state),
        .o_sample(a_sample), .o_err_count(a_err)
    );

    clk_phase_monitor #(
        .ERR_CNT_W(4), .UNLOCK_ERRORS(32)
    ) dut_b (
        .i_cpu_ck(clk), .i_cpu_reset(rst), .i_cpu_ck_ps(ps),
        .i_enable(en), .i_clear_err(clr),
        .o_locked(b_locked), .o_lock_lost(b_lost), .o_state(b_state),
        .o_sample(b_sample), .o_err_count(b_err)
    );

    function automatic int unlock_n(input int c);
        return (c == 0) ? 4 : 32;
    endfunction

    function automatic int err_max(input int c);
        return (c == 0) ? 65535 : 15;
    endfunction

    function automatic int exp_state(input int c);
        if (!m_active[c]) return 0;
        if (!m_locked[c]) return 1;
        return (m_miss[c] > 0) ? 3 : 2;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit ps_s);
        bit match;
        match = (m_sync1 == 1'b0);
        for (int c = 0; c < 2; c++) begin
            m_lost[c] = 1'b0;
            if (rst) begin
                m_active[c] = 0; m_locked[c] = 0; m_run[c] = 0; m_miss[c] = 0; m_err[c] = 0;
            end else begin
                if (clr) m_err[c] = 0;
                else if (en && m_locked[c] && !match && m_err[c] < err_max(c)) m_err[c]++;
                if (!en) begin
                    m_active[c] = 0; m_locked[c] = 0; m_run[c] = 0; m_miss[c] = 0;
                end else if (!m_active[c]) begin
                    m_active[c] = 1; m_run[c] = 0;
                end else if (!m_locked[c]) begin
                    if (match) begin
                        m_run[c]++;
                        if (m_run[c] == 16) begin m_locked[c] = 1; m_miss[c] = 0; end
                    end else begin
                        m_run[c] = 0;
                    end
                end else begin
                    if (match) m_miss[c] = 0;
                    else begin
                        m_miss[c]++;
                        if (m_miss[c] == unlock_n(c)) begin
                            m_locked[c] = 0; m_run[c] = 0; m_miss[c] = 0; m_lost[c] = 1;
                        end
                    end
                end
            end
        end
        if (rst) begin m_sync0 = 0; m_sync1 = 0; end
        else begin m_sync1 = m_sync0; m_sync0 = ps_s; end
    endtask

    task automatic compare_all();
        check("a_state", a_state, exp_state(0));
        check("a_locked", a_locked, m_locked[0]);
        check("a_lock_lost", a_lost, m_lost[0]);
        check("a_sample", a_sample, m_sync1);
        check("a_err_count", a_err, m_err[0]);
        check("b_state", b_state, exp_state(1));
        check("b_locked", b_locked, m_locked[1]);
        check("b_lock_lost", b_lost, m_lost[1]);
        check("b_sample", b_sample, m_sync1);
        check("b_err_count", b_err, m_err[1]);
    endtask

    task automatic tick();
        bit ps_s;
        @(posedge clk);
        ps_s = ps;
        model_step(ps_s);
        #1;
        compare_all();
    endtask

    initial begin
        int lost_cnt;
        bool_dummy: begin end
        // Reset
        rst = 1; en = 0;
        repeat (3) tick();
        check("rst_state", a_state, 0);
        check("rst_err", a_err, 0);
        rst = 0;
        tick();

        // Test 1: nominal lagging clock, lock after 16 edges
        en = 1;
        tick();
        check("t1_state_acquire", a_state, 1);
        for (int i = 1; i <= 16; i++) begin
            tick();
            check("t1_lock_latency", a_locked, (i == 16) ? 1 : 0);
        end
        check("t1_err_zero", a_err, 0);

        // Test 2: two mismatching samples -> SLIP, then back to LOCKED
        force_en = 1; force_val = 1;
        tick(); tick();
        force_en = 0;
        tick(); tick();
        check("t2_state_slip", a_state, 3);
        check("t2_locked_held", a_locked, 1);
        tick(); tick();
        check("t2_state_locked", a_state, 2);
        check("t2_err_two", a_err, 2);

        // Test 3: four mismatches -> lock lost once, then relock
        force_en = 1; force_val = 1;
        repeat (4) tick();
        force_en = 0;
        lost_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (a_lost) lost_cnt++;
        end
        check("t3_lost_pulses", lost_cnt, 1);
        check("t3_err_six", a_err, 6);
        check("t3_relocked", a_locked, 1);

        // Test 4: one mismatch after 10 matches in ACQUIRE restarts the count
        en = 0; tick();
        en = 1; tick();
        repeat (8) tick();
        force_en = 1; force_val = 1;
        tick();
        force_en = 0;
        tick(); tick();
        for (int i = 1; i <= 16; i++) begin
            tick();
            check("t4_relock_latency", a_locked, (i == 16) ? 1 : 0);
        end
        check("t4_err_unchanged", a_err, 6);

        // Test 5: saturation of the 4-bit counter, then clear beats a mismatch
        repeat (4) tick();
        force_en = 1; force_val = 1;
        repeat (22) tick();
        check("t5_b_saturated", b_err, 15);
        check("t5_b_slip", b_state, 3);
        clr = 1;
        tick();
        clr = 0;
        check("t5_b_cleared", b_err, 0);
        force_en = 0;
        repeat (5) tick();

        // Randomized phase disturbances, enable drops, clears and resets
        for (int i = 0; i < 400; i++) begin
            force_en  = ($urandom_range(0, 31) == 0);
            force_val = 1'($urandom_range(0, 1));
            en        = ($urandom_range(0, 63) != 0);
            clr       = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 127) == 0);
            tick();
        end
        rst = 0; en = 1; clr = 0; force_en = 0;

        // Test 6: disable in LOCKED, then reset in SLIP
        repeat (24) tick();
        check("t6_locked_before", a_locked, 1);
        en = 0;
        tick();
        check("t6_idle_state", a_state, 0);
        check("t6_idle_unlocked", a_locked, 0);
        check("t6_no_lost", a_lost, 0);
        en = 1;
        repeat (24) tick();
        force_en = 1; force_val = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (a_state == 2'd3) break;
        end
        check("t6_slip_reached", a_state, 3);
        rst = 1; force_en = 0;
        tick();
        check("t6_rst_state", a_state, 0);
        check("t6_rst_locked", a_locked, 0);
        check("t6_rst_lost", a_lost, 0);
        check("t6_rst_sample", a_sample, 0);
        check("t6_rst_err", a_err, 0);
        rst = 0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
